// File: rtl/gpio_irq_if.sv
// gpio_irq_if: MMIO slot bus between a master and the gpio_irq peripheral
interface gpio_irq_if;
    logic        chip_select;
    logic        read;
    logic        write;
    logic        transaction_completed;
    logic [7:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr_done;
    logic        rd_done;
    logic        idle;
    logic        slave_error;
    logic        decode_error;
    modport master (
        output chip_select, read, write, transaction_completed, addr, wr_data,
        input  rd_data, wr_done, rd_done, idle, slave_error, decode_error
    );
    modport slave (
        input  chip_select, read, write, transaction_completed, addr, wr_data,
        output rd_data, wr_done, rd_done, idle, slave_error, decode_error
    );
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: MMIO GPIO with set/clr/toggle outputs, debounced inputs and edge-capture interrupts
module gpio_irq #(
    parameter int NUM_INPUT  = 9,
    parameter int NUM_OUTPUT = 4,
    parameter int DB_W       = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    gpio_irq_if.slave             bus,
    input  logic [NUM_INPUT-1:0]  in_ports,
    output logic [NUM_OUTPUT-1:0] out_ports,
    output logic                  irq
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state_q, state_d;
    logic [NUM_OUTPUT-1:0] out_q, out_d;
    logic [NUM_INPUT-1:0]  sync1_q, sync2_q, prev_q, prev_d, db_q, db_d;
    logic [NUM_INPUT-1:0]  rise_q, rise_d, fall_q, fall_d, stat_q, stat_d, w1c, eq;
    logic [DB_W-1:0]       dbv_q, dbv_d, cnt_q, cnt_d;
    logic [31:0]           rd_data_q, rd_data_d, rd_word;
    logic                  wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic                  slv_q, slv_d, dec_q, dec_d;
    logic [5:0]            wsel;
    logic                  dec_err, slv_err, acc_ok, wr_ok, bypass, tick;
    assign wsel    = bus.addr[7:2];
    assign dec_err = (bus.addr[1:0] != 2'b00) || (wsel > 6'd8);
    assign slv_err = !dec_err && (bus.write ? (wsel == 6'd4) : (wsel >= 6'd1 && wsel <= 6'd3));
    assign acc_ok  = !dec_err && !slv_err;
    assign wr_ok   = (state_q == ACTIVE) && bus.write && acc_ok;
    always_comb begin
        rd_word = '0;
        case (wsel)
            6'd0:    rd_word[NUM_OUTPUT-1:0] = out_q;
            6'd4:    rd_word[NUM_INPUT-1:0]  = db_q;
            6'd5:    rd_word[NUM_INPUT-1:0]  = rise_q;
            6'd6:    rd_word[NUM_INPUT-1:0]  = fall_q;
            6'd7:    rd_word[NUM_INPUT-1:0]  = stat_q;
            6'd8:    rd_word[DB_W-1:0]       = dbv_q;
            default: rd_word = '0;
        endcase
    end
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        rise_d    = rise_q;
        fall_d    = fall_q;
        dbv_d     = dbv_q;
        w1c       = '0;
        rd_data_d = rd_data_q;
        slv_d     = slv_q;
        dec_d     = dec_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        case (state_q)
            IDLE: state_d = (bus.chip_select && (bus.read || bus.write)) ? ACTIVE : IDLE;
            ACTIVE: begin
                state_d   = DONE;
                wr_done_d = bus.write;
                rd_done_d = !bus.write;
                slv_d     = slv_err;
                dec_d     = dec_err;
                rd_data_d = (!bus.write && acc_ok) ? rd_word : '0;
            end
            DONE: if (bus.transaction_completed) begin
                state_d   = IDLE;
                rd_data_d = '0;
                slv_d     = 1'b0;
                dec_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (wr_ok)
            case (wsel)
                6'd0:    out_d  = bus.wr_data[NUM_OUTPUT-1:0];
                6'd1:    out_d  = out_q | bus.wr_data[NUM_OUTPUT-1:0];
                6'd2:    out_d  = out_q & ~bus.wr_data[NUM_OUTPUT-1:0];
                6'd3:    out_d  = out_q ^ bus.wr_data[NUM_OUTPUT-1:0];
                6'd5:    rise_d = bus.wr_data[NUM_INPUT-1:0];
                6'd6:    fall_d = bus.wr_data[NUM_INPUT-1:0];
                6'd7:    w1c    = bus.wr_data[NUM_INPUT-1:0];
                6'd8:    dbv_d  = bus.wr_data[DB_W-1:0];
                default: out_d  = out_q;
            endcase
    end
    // prev tracks sync in bypass so enabling the debouncer starts from a sane reference
    always_comb begin
        bypass = dbv_q == '0;
        tick   = !bypass && (cnt_q == dbv_q);
        eq     = ~(sync2_q ^ prev_q);
        cnt_d  = ((wr_ok && wsel == 6'd8) || tick || bypass) ? '0 : cnt_q + DB_W'(1);
        prev_d = (tick || bypass) ? sync2_q : prev_q;
        db_d   = bypass ? sync2_q : (tick ? ((db_q & ~eq) | (sync2_q & eq)) : db_q);
        stat_d = (stat_q & ~w1c) | (db_d & ~db_q & rise_q) | (~db_d & db_q & fall_q);
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            stat_q    <= '0;
            dbv_q     <= '0;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            db_q      <= '0;
            rd_data_q <= '0;
            slv_q     <= 1'b0;
            dec_q     <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            stat_q    <= stat_d;
            dbv_q     <= dbv_d;
            cnt_q     <= cnt_d;
            sync1_q   <= in_ports;
            sync2_q   <= sync1_q;
            prev_q    <= prev_d;
            db_q      <= db_d;
            rd_data_q <= rd_data_d;
            slv_q     <= slv_d;
            dec_q     <= dec_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
        end
    end
    assign out_ports        = out_q;
    assign irq              = |stat_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.wr_done      = wr_done_q;
    assign bus.rd_done      = rd_done_q;
    assign bus.slave_error  = slv_q;
    assign bus.decode_error = dec_q;
    assign bus.idle         = !arst && (state_q == IDLE);
endmodule
